prog_timeout_timer: RTL and testbench
=====================================

Name: prog_timeout_timer

Overview:
Programmable seconds timeout timer for the game-control path, generalising the fixed 3-second chain into one configurable block. A clock prescaler produces a 1 ms tick, which is cascaded to 100 ms and then 1 s ticks. A loadable seconds down-counter then raises the timeout. Adds load value, pause/resume, restart, one-shot or periodic mode, and a remaining-time readout for the display and game FSM.

Parameters:
TICKS_PER_MS, 50000, clk cycles per 1 ms tick (50 MHz default); must be >= 2.
SEC_W, 4, width of the seconds load value and remaining-seconds counter.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset; rst=0 resets all state immediately.
enable  in  1  count qualifier; low freezes all counters (pause).
restart  in  1  one-cycle request: latch load_sec, clear the prescalers, start counting.
load_sec  in  SEC_W  timeout length in seconds, sampled only when restart=1.
periodic  in  1  0 = one-shot, 1 = auto-reload; sampled only when restart=1.
timeout  out  1  one-cycle pulse when the programmed interval completes.
expired  out  1  sticky level set with a one-shot timeout; cleared by restart or reset.
running  out  1  high in RUN state.
sec_left  out  SEC_W  remaining whole seconds.
hms_left  out  4  remaining tenths within the current second, 9..0.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE; 2-bit encoding in the package.
- Reset (rst=0, async):
  - state=IDLE; all counters = 0.
  - timeout=0, expired=0, running=0, sec_left=0, hms_left=0.
- Counter chain (only advances in RUN with enable=1):
  - Prescaler counts 0..TICKS_PER_MS-1 and pulses ms_tick at terminal count.
  - ms counter counts 0..99 on ms_tick and pulses hms_tick.
  - hms counter counts 0..9 on hms_tick and pulses sec_tick.
  - Each counter wraps to 0 on its own terminal tick.
  - hms_left = 9 - hms counter.
- restart=1 (highest priority, any state, overrides enable):
  - Latch load_sec into reload register and sec_left; latch periodic.
  - Clear the prescaler, ms and hms counters; clear expired.
  - If load_sec != 0: next state RUN.
  - If load_sec == 0: next state DONE, timeout pulses on the following cycle, expired=1 (also when periodic=1, to avoid a continuous pulse train).
- RUN:
  - enable=0 -> PAUSE; counters hold.
  - On sec_tick with sec_left > 1: sec_left decrements.
  - On sec_tick with sec_left == 1:
    - timeout is registered high for exactly one cycle after that edge.
    - One-shot: sec_left=0, expired=1, state DONE.
    - Periodic: sec_left reloads from the reload register and counting continues with no dead cycle; expired stays 0.
- PAUSE: enable=1 -> RUN, resuming from the held counts; no lost or duplicated ticks.
- DONE: holds until restart; enable is ignored.
- IDLE: only restart leaves it.
- Latency: with enable held high, timeout asserts exactly load_sec*1000*TICKS_PER_MS cycles after the edge that sampled restart, plus 1 registered cycle.
- A restart in the same cycle as a sec_tick wins; no timeout is emitted.
- A reset mid-count aborts immediately; there is no residual pulse.
- Widths:
  - Prescaler width = clog2(TICKS_PER_MS); ms counter 7 bits; hms counter 4 bits.
  - No arithmetic overflow is possible: sec_left never decrements below 1 inside RUN.

Decomposition:
- Package prog_timer_pkg:
  - State enum constants.
  - MS_PER_HMS=100, HMS_PER_SEC=10.
  - clog2 helper function.
- Sub-module mod_tick_counter:
  - Parameter MODULUS; inputs clk, rst, clr, inc.
  - Outputs count and a terminal-count pulse (tc = inc && count==MODULUS-1).
  - Instantiated three times for the prescaler, ms and hms stages.
- Top level holds the FSM, seconds down-counter, reload register and output registers.

Test Plan:
- Run all scenarios with TICKS_PER_MS=2 (one-shot base case): restart with load_sec=3, periodic=0, enable=1 -> timeout single pulse exactly 6000 cycles after restart (+1 registered cycle); expired=1 afterwards; sec_left=0; running=0; no further pulses for 20000 cycles.
- Periodic mode: load_sec=2, periodic=1 -> timeout pulses every 4000 cycles, checked over 5 periods; expired stays 0; sec_left sequence 2,1,2,1...
- Pause: load_sec=1, enable dropped for 777 cycles at cycle 1000 -> timeout at 2000+777 cycles; hms_left and sec_left frozen during the pause.
- Restart mid-run: load_sec=5, then restart with load_sec=1 at cycle 3333 -> timeout 2000 cycles after the second restart and none at the original time. Restart coincident with sec_tick -> no pulse.
- load_sec=0 -> DONE; timeout pulse 1 cycle later; expired=1; repeated for periodic=1 with no repeat pulse.
- Async reset: assert rst=0 mid-count and between clock edges -> all outputs 0 immediately; after release, block stays IDLE until restart.

Source files
------------

// File: rtl/prog_timer_pkg.sv
// Shared constants for the programmable seconds timeout timer: FSM encoding,
// cascade ratios and a width helper.
package prog_timer_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam int unsigned MS_PER_HMS  = 100;
    localparam int unsigned HMS_PER_SEC = 10;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prog_timeout_timer_if.sv
// Control/status bundle between a game controller (master) and the timeout timer (slave).
interface prog_timeout_timer_if #(
    parameter int unsigned SEC_W = 4
);
    logic             enable;
    logic             restart;
    logic [SEC_W-1:0] load_sec;
    logic             periodic;
    logic             timeout;
    logic             expired;
    logic             running;
    logic [SEC_W-1:0] sec_left;
    logic [3:0]       hms_left;

    modport master (
        output enable, restart, load_sec, periodic,
        input  timeout, expired, running, sec_left, hms_left
    );

    modport slave (
        input  enable, restart, load_sec, periodic,
        output timeout, expired, running, sec_left, hms_left
    );

endinterface

// File: rtl/mod_tick_counter.sv
// Modulo-N up-counter with synchronous clear; tc flags the increment that wraps to zero.
module mod_tick_counter
    import prog_timer_pkg::*;
#(
    parameter int unsigned MODULUS = 10,
    parameter int unsigned CW      = clog2(MODULUS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    logic [CW-1:0] countD;

    assign tc = inc && (count == CW'(MODULUS - 1));

    always_comb begin
        countD = count;
        if (clr)      countD = '0;
        else if (tc)  countD = '0;
        else if (inc) countD = count + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else      count <= countD;
    end

endmodule

// File: rtl/prog_timeout_timer.sv
// Programmable seconds timeout: 1 ms / 100 ms / 1 s tick cascade feeding a loadable
// seconds down-counter with pause, restart, one-shot and auto-reload modes.
module prog_timeout_timer
    import prog_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS = 50000,
    parameter int unsigned SEC_W        = 4
) (
    input logic                 clk,
    input logic                 rst,
    prog_timeout_timer_if.slave bus
);

    localparam int unsigned PresW = clog2(TICKS_PER_MS);
    localparam int unsigned MsW   = clog2(MS_PER_HMS);
    localparam int unsigned HmsW  = clog2(HMS_PER_SEC);

    logic [1:0]       stateQ, stateD;
    logic [SEC_W-1:0] secLeftQ, secLeftD;
    logic [SEC_W-1:0] reloadQ, reloadD;
    logic             periodicQ, periodicD;
    logic             timeoutQ, timeoutD;
    logic             expiredQ, expiredD;

    logic             advance, msTick, hmsTick, secTick;
    logic [PresW-1:0] presCount;
    logic [MsW-1:0]   msCount;
    logic [HmsW-1:0]  hmsCount;

    // PAUSE also counts while enable is high so the resume cycle is not lost.
    assign advance = ((stateQ == StRun) || (stateQ == StPause)) && bus.enable && !bus.restart;

    mod_tick_counter #(.MODULUS(TICKS_PER_MS), .CW(PresW)) uPres (
        .clk(clk), .rst(rst), .clr(bus.restart), .inc(advance), .count(presCount), .tc(msTick)
    );

    mod_tick_counter #(.MODULUS(MS_PER_HMS), .CW(MsW)) uMs (
        .clk(clk), .rst(rst), .clr(bus.restart), .inc(msTick), .count(msCount), .tc(hmsTick)
    );

    mod_tick_counter #(.MODULUS(HMS_PER_SEC), .CW(HmsW)) uHms (
        .clk(clk), .rst(rst), .clr(bus.restart), .inc(hmsTick), .count(hmsCount), .tc(secTick)
    );

    always_comb begin
        stateD    = stateQ;
        secLeftD  = secLeftQ;
        reloadD   = reloadQ;
        periodicD = periodicQ;
        timeoutD  = 1'b0;
        expiredD  = expiredQ;
        if (bus.restart) begin
            reloadD   = bus.load_sec;
            secLeftD  = bus.load_sec;
            periodicD = bus.periodic;
            expiredD  = 1'b0;
            if (bus.load_sec != '0) begin
                stateD = StRun;
            end else begin
                // Zero length ends at once, even in periodic mode, to avoid a pulse train.
                stateD   = StDone;
                timeoutD = 1'b1;
                expiredD = 1'b1;
            end
        end else begin
            case (stateQ)
                StRun, StPause: begin
                    stateD = bus.enable ? StRun : StPause;
                    if (secTick) begin
                        if (secLeftQ == SEC_W'(1)) begin
                            timeoutD = 1'b1;
                            if (periodicQ) begin
                                secLeftD = reloadQ;
                            end else begin
                                secLeftD = '0;
                                expiredD = 1'b1;
                                stateD   = StDone;
                            end
                        end else begin
                            secLeftD = secLeftQ - SEC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= StIdle;
            secLeftQ  <= '0;
            reloadQ   <= '0;
            periodicQ <= 1'b0;
            timeoutQ  <= 1'b0;
            expiredQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            secLeftQ  <= secLeftD;
            reloadQ   <= reloadD;
            periodicQ <= periodicD;
            timeoutQ  <= timeoutD;
            expiredQ  <= expiredD;
        end
    end

    assign bus.timeout  = timeoutQ;
    assign bus.expired  = expiredQ;
    assign bus.running  = (stateQ == StRun);
    assign bus.sec_left = secLeftQ;
    // Tenths readout is only meaningful while a count is in progress.
    assign bus.hms_left = ((stateQ == StRun) || (stateQ == StPause))
                          ? 4'(HMS_PER_SEC - 1) - 4'(hmsCount) : 4'd0;

    assert property (@(posedge clk) disable iff (!rst) 32'(presCount) < TICKS_PER_MS);
    assert property (@(posedge clk) disable iff (!rst) 32'(msCount) < MS_PER_HMS);

endmodule

// File: tb/tb_prog_timeout_timer.sv
// Directed bench for prog_timeout_timer with a 2-cycle millisecond (2000 cycles per second).
module tb_prog_timeout_timer;

    localparam int unsigned TICKS_PER_MS = 2;
    localparam int unsigned SEC_W        = 4;
    localparam int          CycPerSec    = 1000 * TICKS_PER_MS;

    logic clk = 1'b0;
    logic rst;
    int   vecCnt = 0;
    int   errCnt = 0;
    int   cyc;
    int   pulses;

    prog_timeout_timer_if #(.SEC_W(SEC_W)) bus ();

    prog_timeout_timer #(.TICKS_PER_MS(TICKS_PER_MS), .SEC_W(SEC_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges after the current one until timeout is seen high; -1 if the bound expires.
    task automatic waitTimeout(input int maxC, output int c);
        c = -1;
        for (int i = 1; i <= maxC; i++) begin
            @(posedge clk);
            #1;
            if (bus.timeout) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic countPulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.timeout) p++;
        end
    endtask

    // Restart is sampled on the next rising edge; returns just after that edge.
    task automatic doRestart(input int ld, input bit per);
        @(negedge clk);
        bus.restart  = 1'b1;
        bus.load_sec = SEC_W'(ld);
        bus.periodic = per;
        @(posedge clk);
        #1;
        bus.restart  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".timeout"},  int'(bus.timeout),  0);
        checkVal({tag, ".expired"},  int'(bus.expired),  0);
        checkVal({tag, ".running"},  int'(bus.running),  0);
        checkVal({tag, ".sec_left"}, int'(bus.sec_left), 0);
        checkVal({tag, ".hms_left"}, int'(bus.hms_left), 0);
    endtask

    initial begin
        rst          = 1'b0;
        bus.enable   = 1'b1;
        bus.restart  = 1'b0;
        bus.load_sec = '0;
        bus.periodic = 1'b0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;
        stepCycles(5);
        checkVal("idle.running", int'(bus.running), 0);

        // One-shot, 3 s.
        doRestart(3, 1'b0);
        checkVal("os.running", int'(bus.running), 1);
        checkVal("os.sec_left0", int'(bus.sec_left), 3);
        checkVal("os.hms_left0", int'(bus.hms_left), 9);
        waitTimeout(3 * CycPerSec + 100, cyc);
        checkVal("os.latency", cyc, 3 * CycPerSec);
        checkVal("os.expired", int'(bus.expired), 1);
        checkVal("os.sec_left", int'(bus.sec_left), 0);
        checkVal("os.running_done", int'(bus.running), 0);
        countPulses(20000, pulses);
        checkVal("os.no_repeat", pulses, 0);
        checkVal("os.expired_hold", int'(bus.expired), 1);

        // Periodic, 2 s: five periods of 4000 cycles, sec_left 2,1,2,1...
        doRestart(2, 1'b1);
        checkVal("per.expired_clr", int'(bus.expired), 0);
        waitTimeout(2 * CycPerSec + 100, cyc);
        checkVal("per.first", cyc, 2 * CycPerSec);
        checkVal("per.reload0", int'(bus.sec_left), 2);
        for (int k = 1; k < 5; k++) begin
            stepCycles(2100);
            checkVal("per.mid", int'(bus.sec_left), 1);
            waitTimeout(2000, cyc);
            checkVal("per.period", cyc, 2 * CycPerSec - 2100);
            checkVal("per.reload", int'(bus.sec_left), 2);
            checkVal("per.expired", int'(bus.expired), 0);
            checkVal("per.running", int'(bus.running), 1);
        end

        // Pause for 777 cycles starting at cycle 1000 of a 1 s count.
        doRestart(1, 1'b0);
        stepCycles(1000);
        checkVal("pause.hms_before", int'(bus.hms_left), 4);
        bus.enable = 1'b0;
        stepCycles(400);
        checkVal("pause.running", int'(bus.running), 0);
        checkVal("pause.hms_frozen", int'(bus.hms_left), 4);
        checkVal("pause.sec_frozen", int'(bus.sec_left), 1);
        stepCycles(377);
        bus.enable = 1'b1;
        waitTimeout(1100, cyc);
        checkVal("pause.latency", cyc, CycPerSec - 1000);
        checkVal("pause.expired", int'(bus.expired), 1);

        // Restart mid-run replaces a 5 s count with a 1 s count.
        doRestart(5, 1'b0);
        stepCycles(3333);
        doRestart(1, 1'b0);
        waitTimeout(CycPerSec + 100, cyc);
        checkVal("rst_mid.latency", cyc, CycPerSec);
        countPulses(8000, pulses);
        checkVal("rst_mid.no_orig", pulses, 0);

        // Restart on the very edge of the final sec_tick suppresses the timeout.
        doRestart(1, 1'b0);
        stepCycles(CycPerSec - 1);
        doRestart(3, 1'b0);
        checkVal("coinc.timeout", int'(bus.timeout), 0);
        checkVal("coinc.sec_left", int'(bus.sec_left), 3);
        checkVal("coinc.hms_left", int'(bus.hms_left), 9);
        countPulses(100, pulses);
        checkVal("coinc.no_pulse", pulses, 0);

        // Zero load: immediate DONE and a single pulse, in both modes.
        doRestart(0, 1'b0);
        checkVal("zero.timeout", int'(bus.timeout), 1);
        checkVal("zero.expired", int'(bus.expired), 1);
        checkVal("zero.running", int'(bus.running), 0);
        countPulses(50, pulses);
        checkVal("zero.single", pulses, 0);
        doRestart(2, 1'b0);
        checkVal("zero.expired_clr", int'(bus.expired), 0);
        doRestart(0, 1'b1);
        checkVal("zero_per.timeout", int'(bus.timeout), 1);
        checkVal("zero_per.expired", int'(bus.expired), 1);
        countPulses(100, pulses);
        checkVal("zero_per.single", pulses, 0);

        // Asynchronous reset between clock edges while counting.
        doRestart(3, 1'b0);
        stepCycles(1500);
        #2;
        rst = 1'b0;
        #1;
        checkVal("areset.hms_pre", int'(bus.hms_left), 0);
        checkAllZero("areset");
        stepCycles(3);
        @(negedge clk);
        rst = 1'b1;
        countPulses(7000, pulses);
        checkVal("areset.no_pulse", pulses, 0);
        checkVal("areset.idle_running", int'(bus.running), 0);
        checkVal("areset.idle_sec", int'(bus.sec_left), 0);
        doRestart(1, 1'b0);
        checkVal("areset.leave_idle", int'(bus.running), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
